// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central pipeline controller: stall merge, counted multi-cycle EX sequencing, exception flush
//
// Purpose:
//   Merges per-stage stall requests into a 6-bit stall vector (MEM > EX > ID > IF),
//   sequences counted multi-cycle EX operations (e.g. iterative divide), and converts
//   a MEM-stage exception into a single-cycle flush pulse carrying the redirect PC.
//
// Parameters:
//   MC_CYCLES     EX cycles occupied by a counted multi-cycle op (2..64)
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous active-low reset
//   stallreq_if   in   1   IF stage not ready
//   stallreq_id   in   1   ID load-use hazard
//   stallreq_ex   in   1   EX uncounted stall request
//   stallreq_mem  in   1   MEM stage not ready
//   ex_mc_start   in   1   EX begins a counted multi-cycle op
//   excp_i        in   1   MEM exception this cycle
//   excp_pc_i     in   32  handler PC accompanying excp_i
//   stall         out  6   {WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}, 1 = hold
//   flush         out  1   one-cycle registered flush pulse
//   new_pc        out  32  redirect PC, valid while flush=1
//   mc_busy       out  1   counted op in progress
//   mc_done       out  1   counted op result valid in EX this cycle

module pipe_ctrl #(
  parameter int MC_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ex_mc_start,
  input  logic        excp_i,
  input  logic [31:0] excp_pc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_busy,
  output logic        mc_done
);

  localparam int CNT_W = $clog2(MC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MC    = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [31:0]       r_new_pc;
  logic [31:0]       w_new_pc_nxt;
  logic              r_flush;
  logic              r_mc_busy;
  logic              r_mc_done;
  logic              w_cnt_zero;
  logic              w_ex_req;

  assign w_cnt_zero = (r_cnt == '0);

  // A start pulse only counts as an EX request while idle; once counting,
  // the countdown itself holds EX until it reaches zero.
  assign w_ex_req = stallreq_ex
                  | (ex_mc_start && (r_state == ST_IDLE))
                  | ((r_state == ST_MC) && !w_cnt_zero);

  // Stall merge: each deeper request freezes its own stage and everything upstream.
  always_comb begin
    stall = 6'b000000;
    if (r_state != ST_FLUSH) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (w_ex_req)    stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
      else if (stallreq_if) stall = 6'b000011;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_new_pc_nxt = r_new_pc;
    case (r_state)
      ST_IDLE: begin
        if (excp_i) begin
          w_state_nxt  = ST_FLUSH;
          w_cnt_nxt    = '0;
          w_new_pc_nxt = excp_pc_i;
        end else if (ex_mc_start) begin
          w_state_nxt = ST_MC;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_MC: begin
        if (excp_i) begin
          w_state_nxt  = ST_FLUSH;
          w_cnt_nxt    = '0;
          w_new_pc_nxt = excp_pc_i;
        end else if (!w_cnt_zero) begin
          // The divider runs free, so the countdown ignores MEM backpressure.
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!stallreq_mem) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs are registered decodes of the next state so they never
  // glitch on state-bit transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_new_pc  <= 32'h0;
      r_flush   <= 1'b0;
      r_mc_busy <= 1'b0;
      r_mc_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_new_pc  <= w_new_pc_nxt;
      r_flush   <= (w_state_nxt == ST_FLUSH);
      r_mc_busy <= (w_state_nxt == ST_MC);
      r_mc_done <= (w_state_nxt == ST_MC) && (w_cnt_nxt == '0);
    end
  end

  assign flush   = r_flush;
  assign new_pc  = r_new_pc;
  assign mc_busy = r_mc_busy;
  assign mc_done = r_mc_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        ex_mc_start;
  logic        excp_i;
  logic [31:0] excp_pc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;

  int n_pass;
  int n_total;

  pipe_ctrl #(.MC_CYCLES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .ex_mc_start  (ex_mc_start),
    .excp_i       (excp_i),
    .excp_pc_i    (excp_pc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    ex_mc_start  = 1'b0;
    excp_i       = 1'b0;
    excp_pc_i    = 32'h0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    stallreq_if = 1'b1;
    next_cycle();
    next_cycle();
    n_total++;
    if ({flush, mc_busy, mc_done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {flush, mc_busy, mc_done});
    else n_pass++;
    n_total++;
    if (new_pc !== 32'h0) $display("FAIL reset_new_pc: got %h want 00000000", new_pc);
    else n_pass++;
    n_total++;
    if (stall !== 6'b000011) $display("FAIL reset_stall: got %b want 000011", stall);
    else n_pass++;
    clear_inputs();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_priority();
    logic [3:0] req [0:5];
    logic [5:0] exp [0:5];
    // req = {mem, ex, id, if}
    req[0] = 4'b0001; exp[0] = 6'b000011;
    req[1] = 4'b0011; exp[1] = 6'b000111;
    req[2] = 4'b1010; exp[2] = 6'b011111;
    req[3] = 4'b0000; exp[3] = 6'b000000;
    req[4] = 4'b0111; exp[4] = 6'b001111;
    req[5] = 4'b1111; exp[5] = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req[i];
      #1;
      n_total++;
      if (stall !== exp[i]) $display("FAIL priority_%0d: got %b want %b", i, stall, exp[i]);
      else n_pass++;
    end
    clear_inputs();
    next_cycle();
  endtask

  // Counted op started at cycle 10; optional MEM backpressure during cycles 40..45.
  // With backpressure, MEM is still high in cycle 45 so MC (cnt=0) persists through
  // cycle 46 and the block is idle from cycle 47.
  task automatic run_counted(input bit with_mem);
    logic [5:0] e_stall;
    logic       e_busy;
    logic       e_done;
    int         last;
    last = with_mem ? 48 : 44;
    for (int c = 0; c <= last; c++) begin
      ex_mc_start  = (c == 10);
      stallreq_mem = with_mem && (c >= 40) && (c <= 45);
      #1;
      if (with_mem) begin
        e_stall = (c >= 40 && c <= 45) ? 6'b011111 : (c >= 10 && c <= 39) ? 6'b001111 : 6'b000000;
        e_busy  = (c >= 11 && c <= 46);
        e_done  = (c >= 42 && c <= 46);
      end else begin
        e_stall = (c >= 10 && c <= 41) ? 6'b001111 : 6'b000000;
        e_busy  = (c >= 11 && c <= 42);
        e_done  = (c == 42);
      end
      n_total++;
      if (stall !== e_stall) $display("FAIL counted_stall mem=%0d c=%0d: got %b want %b", with_mem, c, stall, e_stall);
      else n_pass++;
      n_total++;
      if (mc_busy !== e_busy) $display("FAIL counted_busy mem=%0d c=%0d: got %b want %b", with_mem, c, mc_busy, e_busy);
      else n_pass++;
      n_total++;
      if (mc_done !== e_done) $display("FAIL counted_done mem=%0d c=%0d: got %b want %b", with_mem, c, mc_done, e_done);
      else n_pass++;
      n_total++;
      if (flush !== 1'b0) $display("FAIL counted_flush mem=%0d c=%0d: got %b want 0", with_mem, c, flush);
      else n_pass++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_counted_op();
    run_counted(1'b0);
  endtask

  task automatic test_mem_backpressure();
    run_counted(1'b1);
  endtask

  task automatic test_exception_abort();
    for (int c = 0; c <= 26; c++) begin
      ex_mc_start = (c == 10);
      excp_i      = (c == 20);
      excp_pc_i   = (c == 20) ? 32'hBFC00380 : 32'h12345678;
      #1;
      n_total++;
      if (mc_done !== 1'b0) $display("FAIL abort_done c=%0d: got %b want 0", c, mc_done);
      else n_pass++;
      n_total++;
      if (flush !== (c == 21)) $display("FAIL abort_flush c=%0d: got %b want %b", c, flush, (c == 21));
      else n_pass++;
      n_total++;
      if (mc_busy !== (c >= 11 && c <= 20)) $display("FAIL abort_busy c=%0d: got %b want %b", c, mc_busy, (c >= 11 && c <= 20));
      else n_pass++;
      n_total++;
      if (stall !== ((c >= 10 && c <= 20) ? 6'b001111 : 6'b000000))
        $display("FAIL abort_stall c=%0d: got %b want %b", c, stall, ((c >= 10 && c <= 20) ? 6'b001111 : 6'b000000));
      else n_pass++;
      if (c >= 21) begin
        n_total++;
        if (new_pc !== 32'hBFC00380) $display("FAIL abort_new_pc c=%0d: got %h want bfc00380", c, new_pc);
        else n_pass++;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_excp_with_start();
    excp_i      = 1'b1;
    ex_mc_start = 1'b1;
    excp_pc_i   = 32'h80000180;
    next_cycle();
    clear_inputs();
    #1;
    n_total++;
    if ({flush, mc_busy} !== 2'b10) $display("FAIL excp_start_t1: got flush,busy=%b want 10", {flush, mc_busy});
    else n_pass++;
    n_total++;
    if (new_pc !== 32'h80000180) $display("FAIL excp_start_pc: got %h want 80000180", new_pc);
    else n_pass++;
    next_cycle();
    n_total++;
    if ({flush, mc_busy, mc_done} !== 3'b000) $display("FAIL excp_start_t2: got %b want 000", {flush, mc_busy, mc_done});
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_excp_mem_and_second_excp();
    excp_i       = 1'b1;
    stallreq_mem = 1'b1;
    excp_pc_i    = 32'hA0001000;
    #1;
    n_total++;
    if (stall !== 6'b011111) $display("FAIL excp_mem_stall: got %b want 011111", stall);
    else n_pass++;
    next_cycle();
    // In FLUSH: a second exception and all requests are ignored.
    excp_i       = 1'b1;
    excp_pc_i    = 32'hDEADBEEF;
    stallreq_mem = 1'b1;
    ex_mc_start  = 1'b1;
    #1;
    n_total++;
    if (flush !== 1'b1) $display("FAIL excp_mem_flush: got %b want 1", flush);
    else n_pass++;
    n_total++;
    if (stall !== 6'b000000) $display("FAIL flush_stall: got %b want 000000", stall);
    else n_pass++;
    next_cycle();
    clear_inputs();
    #1;
    n_total++;
    if ({flush, mc_busy} !== 2'b00) $display("FAIL second_excp_flags: got %b want 00", {flush, mc_busy});
    else n_pass++;
    n_total++;
    if (new_pc !== 32'hA0001000) $display("FAIL second_excp_pc: got %h want a0001000", new_pc);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_async_reset();
    ex_mc_start = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
    next_cycle();
    n_total++;
    if (mc_busy !== 1'b1) $display("FAIL async_pre_busy: got %b want 1", mc_busy);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({mc_busy, mc_done, flush} !== 3'b000) $display("FAIL async_mc: got %b want 000", {mc_busy, mc_done, flush});
    else n_pass++;
    rst = 1'b1;
    next_cycle();
    excp_i    = 1'b1;
    excp_pc_i = 32'h00000200;
    next_cycle();
    clear_inputs();
    n_total++;
    if (flush !== 1'b1) $display("FAIL async_pre_flush: got %b want 1", flush);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({flush, new_pc} !== {1'b0, 32'h0}) $display("FAIL async_flush: got flush=%b pc=%h want 0 00000000", flush, new_pc);
    else n_pass++;
    rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_priority();
    do_reset();
    test_counted_op();
    do_reset();
    test_mem_backpressure();
    do_reset();
    test_exception_abort();
    do_reset();
    test_excp_with_start();
    do_reset();
    test_excp_mem_and_second_excp();
    do_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
